// File: rtl/fetchflare_pref_sched_if.sv
// Bundle of the prefetch request, memory slot, response and flush signals
// shared between the requester/memory side (master) and the scheduler (slave).
interface fetchflare_pref_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mem_valid;
  logic [ADDR_W-1:0]         mem_addr;
  logic [ID_W-1:0]           mem_id;
  logic                      mem_ready;
  logic                      rsp_valid;
  logic                      flush;
  logic                      flush_done;
  logic                      busy;
  logic                      rsp_err;

  modport master (
    output req_valid, req_addr, mem_ready, rsp_valid, flush,
    input  req_ready, mem_valid, mem_addr, mem_id, flush_done, busy, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, mem_ready, rsp_valid, flush,
    output req_ready, mem_valid, mem_addr, mem_id, flush_done, busy, rsp_err
  );
endinterface

// File: rtl/fetchflare_pref_sched.sv
// Round-robin scheduler sharing one prefetch-memory port between NUM_REQ
// requesters, with a registered output slot, an in-flight credit limit and
// a flush/drain sequence.
//
// state | meaning
// RUN   | normal operation, requests may be accepted
// DRAIN | flush seen; no accepts, waiting for slot and credits to empty
// DONE  | drain finished; flush_done is high for this single cycle
// HOLD  | flush still asserted after DONE; no accepts until it drops
module fetchflare_pref_sched #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  fetchflare_pref_sched_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t              state;
  logic [NUM_REQ-1:0]  pr;
  logic [NUM_REQ-1:0]  masked;
  logic [NUM_REQ-1:0]  pick_src;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  pr_above;
  logic [ID_W-1:0]     winner;
  logic                found;
  logic [CNT_W-1:0]    cnt;
  logic                can_issue;
  logic                accept;
  logic                mem_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [ID_W-1:0]     mem_id_q;
  logic                flush_done_q;
  logic                rsp_err_q;

  // Round-robin pick: lowest valid requester above the last winner, else
  // wrap around to the lowest valid requester overall.
  always_comb begin
    masked   = bus.req_valid & pr;
    pick_src = (|masked) ? masked : bus.req_valid;
    grant    = '0;
    winner   = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_src[i] && !found) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        winner   = ID_W'(i);
      end
    end
  end

  // Priority mask for the next round: only indices strictly above the winner.
  always_comb begin
    pr_above = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pr_above[i] = (i > int'(winner));
    end
  end

  // Issue allowed only while running, not flushing, slot free or freeing,
  // and a credit available from the registered count.
  assign can_issue = (state == ST_RUN) && !bus.flush &&
                     (!mem_valid_q || bus.mem_ready) && (cnt < CNT_MAX);

  // Gated with reset so no strobe escapes while reset is held low.
  assign bus.req_ready = grant & {NUM_REQ{can_issue && reset}};
  assign accept        = |bus.req_ready;

  // Rotate the priority mask after every accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pr <= '1;
    end else if (accept) begin
      pr <= pr_above;
    end
  end

  // Output slot: load on accept, retire on downstream handshake, hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_id_q    <= '0;
    end else if (accept) begin
      mem_valid_q <= 1'b1;
      mem_addr_q  <= bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
      mem_id_q    <= winner;
    end else if (mem_valid_q && bus.mem_ready) begin
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_id_q    <= '0;
    end
  end

  // In-flight credit counter; a response with nothing outstanding is flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept && !bus.rsp_valid) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!accept && bus.rsp_valid) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else begin
          rsp_err_q <= 1'b1;
        end
      end
    end
  end

  // Flush sequencing with a registered single-cycle done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt == '0 && !mem_valid_q) begin
            state        <= ST_DONE;
            flush_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= bus.flush ? ST_HOLD : ST_RUN;
        end
        ST_HOLD: begin
          if (!bus.flush) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_id     = mem_id_q;
  assign bus.flush_done = flush_done_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (cnt != '0) || mem_valid_q;
endmodule
